// File: rtl/viterbi_decode_if.sv
// viterbi_decode_if
//   Symbol/decoded-bit bus for the K=3, rate-1/2 hard-decision Viterbi decoder.
//   Signals:
//     sym_sig   [1:0]  received symbol ([1]=g0 bit, [0]=g1 bit)
//     sym_valid        symbol accepted on this edge
//     dec_sig          decoded data bit
//     dec_valid        one-cycle strobe qualifying dec_sig
//     err_cnt  [15:0]  channel-error estimate (present only with VITERBI_ERRCNT_EN)
//   Modports: master = symbol source / result sink, slave = decoder.
interface viterbi_decode_if;
  logic [1:0]  sym_sig;
  logic        sym_valid;
  logic        dec_sig;
  logic        dec_valid;
`ifdef VITERBI_ERRCNT_EN
  logic [15:0] err_cnt;

  modport master (output sym_sig, output sym_valid,
                  input dec_sig, input dec_valid, input err_cnt);
  modport slave  (input sym_sig, input sym_valid,
                  output dec_sig, output dec_valid, output err_cnt);
`else
  modport master (output sym_sig, output sym_valid,
                  input dec_sig, input dec_valid);
  modport slave  (input sym_sig, input sym_valid,
                  output dec_sig, output dec_valid);
`endif
endinterface

// File: rtl/viterbi_decode.sv
// viterbi_decode
//   Hard-decision Viterbi decoder for the K=3, rate-1/2 code (g0=7, g1=5 octal).
//   Four-state add-compare-select with register-exchange survivor paths of
//   TB_DEPTH bits; one decoded bit per accepted symbol, TB_DEPTH symbols late.
//   Ports:
//     clk_sig  in   clock, rising edge
//     rst_sig  in   synchronous reset, active-high (priority over sym_valid)
//     bus      slave modport of viterbi_decode_if (sym_sig/sym_valid in,
//              dec_sig/dec_valid out, err_cnt out when enabled)
//   Optional feature: define VITERBI_ERRCNT_EN to build the 16-bit saturating
//   channel-error counter (sum of normalisation amounts).
//   State encoding: s = {d1,d2}; input b moves {c,e} -> {b,c} emitting
//   {b^c^e, b^e}.
module viterbi_decode #(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 4
) (
  input  logic             clk_sig,
  input  logic             rst_sig,
  viterbi_decode_if.slave  bus
);

  localparam int            CNT_W   = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0] PM_MAX  = '1;
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(4);

  logic [PM_W-1:0]     pm_q   [4];
  logic [PM_W-1:0]     pm_d   [4];
  logic [TB_DEPTH-1:0] path_q [4];
  logic [TB_DEPTH-1:0] path_d [4];
  logic [PM_W:0]       raw    [4];
  logic [PM_W:0]       m;
  logic [1:0]          best;
  logic [CNT_W-1:0]    sym_cnt_q;
  logic                dec_q;
  logic                dec_vld_q;

  // Encoder output for the transition {c,e} -> {b,c}.
  function automatic logic [1:0] exp_sym(input logic b, input logic c, input logic e);
    return {b ^ c ^ e, b ^ e};
  endfunction

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] x);
    logic [1:0] d;
    d = a ^ x;
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_pm(input logic [PM_W:0] v);
    if (v > {1'b0, PM_MAX}) return PM_MAX;
    return v[PM_W-1:0];
  endfunction

  // Add-compare-select, one slice per new state {b,c}; predecessors {c,0}/{c,1}.
  for (genvar s = 0; s < 4; s++) begin : g_acs
    localparam int B  = s / 2;
    localparam int C  = s % 2;
    localparam int P0 = C * 2;
    localparam int P1 = C * 2 + 1;

    logic [1:0]          bm0, bm1;
    logic [PM_W:0]       r0, r1;
    logic                sel;
    logic [TB_DEPTH-1:0] surv;

    assign bm0  = hamming(bus.sym_sig, exp_sym(1'(B), 1'(C), 1'b0));
    assign bm1  = hamming(bus.sym_sig, exp_sym(1'(B), 1'(C), 1'b1));
    assign r0   = {1'b0, pm_q[P0]} + (PM_W+1)'(bm0);
    assign r1   = {1'b0, pm_q[P1]} + (PM_W+1)'(bm1);
    // Strict compare: ties go to predecessor {c,0}.
    assign sel  = (r1 < r0);
    assign raw[s]    = sel ? r1 : r0;
    assign surv      = sel ? path_q[P1] : path_q[P0];
    assign path_d[s] = {surv[TB_DEPTH-2:0], 1'(B)};
    assign pm_d[s]   = sat_pm(raw[s] - m);
  end

  always_comb begin
    m = raw[0];
    for (int i = 1; i < 4; i++) begin
      if (raw[i] < m) m = raw[i];
    end
  end

  // Lowest-index zero-metric state; scanning downward lets the lowest win.
  always_comb begin
    best = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pm_q[i] == '0) best = 2'(i);
    end
  end

  always_ff @(posedge clk_sig) begin
    if (rst_sig) begin
      pm_q[0]   <= '0;
      pm_q[1]   <= PM_INIT;
      pm_q[2]   <= PM_INIT;
      pm_q[3]   <= PM_INIT;
      for (int i = 0; i < 4; i++) path_q[i] <= '0;
      sym_cnt_q <= '0;
      dec_q     <= 1'b0;
      dec_vld_q <= 1'b0;
    end else if (bus.sym_valid) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= pm_d[i];
        path_q[i] <= path_d[i];
      end
      if (sym_cnt_q < CNT_W'(TB_DEPTH)) sym_cnt_q <= sym_cnt_q + 1'b1;
      // Emit from the pre-update survivor so bit j leaves with symbol j+TB_DEPTH.
      if (sym_cnt_q == CNT_W'(TB_DEPTH)) begin
        dec_vld_q <= 1'b1;
        dec_q     <= path_q[best][TB_DEPTH-1];
      end else begin
        dec_vld_q <= 1'b0;
      end
    end else begin
      dec_vld_q <= 1'b0;
    end
  end

  assign bus.dec_sig   = dec_q;
  assign bus.dec_valid = dec_vld_q;

`ifdef VITERBI_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_sig) begin
    if (rst_sig) begin
      err_cnt_q <= '0;
    end else if (bus.sym_valid) begin
      if (err_cnt_q > 16'hFFFF - 16'(m)) err_cnt_q <= 16'hFFFF;
      else                                err_cnt_q <= err_cnt_q + 16'(m);
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule
